// File: rtl/axis_frame_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_checker_pkg
//  Description : Shared constants and types for the AXI-Stream frame checker.
//                Holds the FSM state encoding, the LFSR seed/tap constants
//                used by the ready throttle, and a constant clog2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_frame_checker_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,   // checking payload beats against BASE + idx
        ST_DRAIN = 1'b1    // frame overran N_WORDS; discard until tlast
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_frame_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_checker_if
//  Description : AXI-Stream payload channel (tdata/tvalid/tready/tlast).
//                master modport = source side, slave modport = sink side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_frame_checker_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_ready_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : axis_ready_lfsr
//  Description : Pseudo-random ready generator. A 16-bit Fibonacci LFSR
//                advances on every enabled cycle; the registered ready is
//                the OR of its two low bits (~75% duty).
//  Ports       : clk, aresetn (sync, active-low), i_en (advance enable),
//                o_ready (registered throttled ready)
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_ready_lfsr
    import axis_frame_checker_pkg::*;
(
    input  logic clk,
    input  logic aresetn,
    input  logic i_en,
    output logic o_ready
);

    logic [15:0] r_lfsr;
    logic        r_ready;
    logic        w_feedback;

    assign w_feedback = ^(r_lfsr & c_lfsr_taps);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_lfsr  <= c_lfsr_seed;
            r_ready <= 1'b0;
        end else if (i_en) begin
            r_lfsr  <= {r_lfsr[14:0], w_feedback};
            r_ready <= r_lfsr[0] | r_lfsr[1];
        end
    end

    assign o_ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/axis_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_checker
//  Description : AXI-Stream sink for fixed-length counting-pattern frames.
//                Each beat is checked against BASE + idx, frame length is
//                checked via tlast, and saturating good/bad/error counters
//                plus a first-mismatch capture are maintained.
//  Ports       : clk, aresetn (sync, active-low), clr (counter clear pulse)
//                s_axis          - AXI-Stream slave (tready registered)
//                frames_ok/bad   - frame statistics
//                beat_err        - mismatched data beats
//                err_sticky      - any error since reset/clr
//                first_err_idx/_data - capture of first data mismatch
//                frame_done/frame_ok - per-frame result pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_checker
    import axis_frame_checker_pkg::*;
#(
    parameter int           W          = 32,
    parameter int           N_WORDS    = 32,
    parameter logic [W-1:0] BASE       = W'(32'h11110000),
    parameter int           READY_MODE = 0,
    parameter int           CNT_W      = 32
)(
    input  logic                clk,
    input  logic                aresetn,
    input  logic                clr,
    axis_frame_checker_if.slave s_axis,
    output logic [CNT_W-1:0]    frames_ok,
    output logic [CNT_W-1:0]    frames_bad,
    output logic [CNT_W-1:0]    beat_err,
    output logic                err_sticky,
    output logic [15:0]         first_err_idx,
    output logic [W-1:0]        first_err_data,
    output logic                frame_done,
    output logic                frame_ok
);

    localparam int                c_idx_w    = (clog2(N_WORDS) < 1) ? 1 : clog2(N_WORDS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_WORDS - 1);

    // ------------------------------------------------------------------
    // Ready generation
    // ------------------------------------------------------------------
    logic w_ready;

    if (READY_MODE == 1) begin : g_lfsr_ready
        axis_ready_lfsr u_ready (
            .clk     (clk),
            .aresetn (aresetn),
            .i_en    (1'b1),
            .o_ready (w_ready)
        );
    end else begin : g_const_ready
        logic r_ready_one;
        always_ff @(posedge clk) begin
            if (!aresetn) r_ready_one <= 1'b0;
            else          r_ready_one <= 1'b1;
        end
        assign w_ready = r_ready_one;
    end

    assign s_axis.tready = w_ready;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t             r_state, w_state_nxt;
    logic [c_idx_w-1:0] r_idx, w_idx_nxt;
    logic               r_frame_bad, w_frame_bad_nxt;
    logic               w_accept;
    logic [W-1:0]       w_expected;
    logic               w_mismatch;
    logic               w_end;
    logic               w_end_good;

    assign w_accept   = s_axis.tvalid & w_ready;
    assign w_expected = BASE + W'(r_idx);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state     <= ST_RUN;
            r_idx       <= '0;
            r_frame_bad <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_frame_bad <= w_frame_bad_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_frame_bad_nxt = r_frame_bad;
        w_mismatch      = 1'b0;
        w_end           = 1'b0;
        w_end_good      = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_RUN: begin
                    w_mismatch = (s_axis.tdata != w_expected);
                    if (s_axis.tlast) begin
                        // Short frames end here too; only the exact length is good
                        w_end           = 1'b1;
                        w_end_good      = !r_frame_bad && !w_mismatch && (r_idx == c_last_idx);
                        w_idx_nxt       = '0;
                        w_frame_bad_nxt = 1'b0;
                    end else if (r_idx == c_last_idx) begin
                        // Overrun: the bad count is deferred to the tlast beat
                        w_state_nxt     = ST_DRAIN;
                        w_idx_nxt       = '0;
                        w_frame_bad_nxt = 1'b1;
                    end else begin
                        w_idx_nxt       = r_idx + c_idx_w'(1);
                        w_frame_bad_nxt = r_frame_bad | w_mismatch;
                    end
                end
                ST_DRAIN: begin
                    if (s_axis.tlast) begin
                        w_end           = 1'b1;
                        w_state_nxt     = ST_RUN;
                        w_idx_nxt       = '0;
                        w_frame_bad_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Statistics, sticky flag and first-mismatch capture
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_frames_ok, r_frames_bad, r_beat_err;
    logic             r_err_sticky;
    logic [15:0]      r_first_err_idx;
    logic [W-1:0]     r_first_err_data;
    logic             r_frame_done, r_frame_ok;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_frames_ok      <= '0;
            r_frames_bad     <= '0;
            r_beat_err       <= '0;
            r_err_sticky     <= 1'b0;
            r_first_err_idx  <= '0;
            r_first_err_data <= '0;
            r_frame_done     <= 1'b0;
            r_frame_ok       <= 1'b0;
        end else begin
            r_frame_done <= w_end;
            r_frame_ok   <= w_end_good;
            if (clr) begin
                // A beat accepted alongside clr has its statistics dropped
                r_frames_ok      <= '0;
                r_frames_bad     <= '0;
                r_beat_err       <= '0;
                r_err_sticky     <= 1'b0;
                r_first_err_idx  <= '0;
                r_first_err_data <= '0;
            end else begin
                if (w_end && w_end_good && (r_frames_ok != '1))
                    r_frames_ok <= r_frames_ok + CNT_W'(1);
                if (w_end && !w_end_good && (r_frames_bad != '1))
                    r_frames_bad <= r_frames_bad + CNT_W'(1);
                if (w_mismatch && (r_beat_err != '1))
                    r_beat_err <= r_beat_err + CNT_W'(1);
                if (w_mismatch || (w_end && !w_end_good))
                    r_err_sticky <= 1'b1;
                if (w_mismatch && !r_err_sticky) begin
                    r_first_err_idx  <= 16'(r_idx);
                    r_first_err_data <= s_axis.tdata;
                end
            end
        end
    end

    assign frames_ok      = r_frames_ok;
    assign frames_bad     = r_frames_bad;
    assign beat_err       = r_beat_err;
    assign err_sticky     = r_err_sticky;
    assign first_err_idx  = r_first_err_idx;
    assign first_err_data = r_first_err_data;
    assign frame_done     = r_frame_done;
    assign frame_ok       = r_frame_ok;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_frame_checker
//  Description : Self-checking bench for axis_frame_checker. Three DUTs:
//                [0] READY_MODE=0, [1] READY_MODE=1, [2] READY_MODE=0 with
//                3-bit counters mirroring [0]. Frame results are predicted
//                from whole-frame rules and queued; monitors pop on
//                frame_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_checker;

    localparam int          W        = 32;
    localparam int          N        = 32;
    localparam logic [31:0] BASE     = 32'h11110000;
    localparam int          SMALL_MX = 7;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        clr;
    logic [31:0] drv_data;
    logic        drv_valid;
    logic        drv_last;
    int          sel;
    logic        cur_ready;

    always #5 clk = ~clk;

    axis_frame_checker_if #(.W(W)) if0();
    axis_frame_checker_if #(.W(W)) if1();
    axis_frame_checker_if #(.W(W)) if2();

    assign if0.tdata  = drv_data;
    assign if0.tlast  = drv_last;
    assign if0.tvalid = drv_valid && (sel == 0);
    assign if2.tdata  = drv_data;
    assign if2.tlast  = drv_last;
    assign if2.tvalid = drv_valid && (sel == 0);
    assign if1.tdata  = drv_data;
    assign if1.tlast  = drv_last;
    assign if1.tvalid = drv_valid && (sel == 1);
    assign cur_ready  = (sel == 1) ? if1.tready : if0.tready;

    logic [31:0] f_ok [2], f_bad [2], b_err [2], cdata [2];
    logic [15:0] cidx [2];
    logic        stky [2], fdone [2], fok [2];
    logic [2:0]  s_ok, s_bad, s_berr;
    logic        s_stky, s_fdone, s_fok;
    logic [15:0] s_cidx;
    logic [31:0] s_cdata;

    axis_frame_checker #(.W(W), .N_WORDS(N), .BASE(BASE), .READY_MODE(0), .CNT_W(32)) u_dut0 (
        .clk(clk), .aresetn(aresetn), .clr(clr), .s_axis(if0),
        .frames_ok(f_ok[0]), .frames_bad(f_bad[0]), .beat_err(b_err[0]),
        .err_sticky(stky[0]), .first_err_idx(cidx[0]), .first_err_data(cdata[0]),
        .frame_done(fdone[0]), .frame_ok(fok[0]));

    axis_frame_checker #(.W(W), .N_WORDS(N), .BASE(BASE), .READY_MODE(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .aresetn(aresetn), .clr(clr), .s_axis(if1),
        .frames_ok(f_ok[1]), .frames_bad(f_bad[1]), .beat_err(b_err[1]),
        .err_sticky(stky[1]), .first_err_idx(cidx[1]), .first_err_data(cdata[1]),
        .frame_done(fdone[1]), .frame_ok(fok[1]));

    axis_frame_checker #(.W(W), .N_WORDS(N), .BASE(BASE), .READY_MODE(0), .CNT_W(3)) u_dut2 (
        .clk(clk), .aresetn(aresetn), .clr(clr), .s_axis(if2),
        .frames_ok(s_ok), .frames_bad(s_bad), .beat_err(s_berr),
        .err_sticky(s_stky), .first_err_idx(s_cidx), .first_err_data(s_cdata),
        .frame_done(s_fdone), .frame_ok(s_fok));

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    int          tests = 0;
    int          fails = 0;
    int          ready_low = 0;
    bit          exp_q0 [$];
    bit          exp_q1 [$];
    logic [31:0] tx_q [$];

    int unsigned m_ok [2], m_bad [2], m_berr [2];
    bit          m_sticky [2];
    logic [15:0] m_cidx [2];
    logic [31:0] m_cdata [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_clr();
        for (int s = 0; s < 2; s++) begin
            m_ok[s] = 0; m_bad[s] = 0; m_berr[s] = 0;
            m_sticky[s] = 0; m_cidx[s] = '0; m_cdata[s] = '0;
        end
    endtask

    // Whole-frame prediction: only the first N beats are data-checked; the
    // frame is good iff exactly N beats and none mismatched. A clr on beat
    // clr_at wipes earlier statistics and drops that beat's own effects.
    task automatic model_frame(input int s, input int clr_at);
        int len;
        int checked;
        bit good;
        bit mis;
        len     = tx_q.size();
        checked = (len < N) ? len : N;
        good    = (len == N);
        for (int k = 0; k < checked; k++)
            if (tx_q[k] != BASE + 32'(k)) good = 0;
        if (s == 0) exp_q0.push_back(good);
        else        exp_q1.push_back(good);
        for (int k = 0; k < len; k++) begin
            if (k == clr_at) begin
                model_clr();
                continue;
            end
            mis = (k < checked) && (tx_q[k] != BASE + 32'(k));
            if (mis) begin
                m_berr[s]++;
                if (!m_sticky[s]) begin
                    m_cidx[s]  = 16'(k);
                    m_cdata[s] = tx_q[k];
                end
                m_sticky[s] = 1;
            end
            if (k == len - 1) begin
                if (good) m_ok[s]++;
                else begin
                    m_bad[s]++;
                    m_sticky[s] = 1;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitors: pop expected frame result on each frame_done pulse
    // ------------------------------------------------------------------
    bit e0, e1;
    always @(negedge clk) begin
        if (aresetn) begin
            if (fdone[0]) begin
                if (exp_q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL frame_done0_unexpected: got pulse expected none");
                end else begin
                    e0 = exp_q0.pop_front();
                    check("frame_ok0", 32'(fok[0]), 32'(e0));
                end
            end
            if (fdone[1]) begin
                if (exp_q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL frame_done1_unexpected: got pulse expected none");
                end else begin
                    e1 = exp_q1.pop_front();
                    check("frame_ok1", 32'(fok[1]), 32'(e1));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver (all calls made at a falling edge)
    // ------------------------------------------------------------------
    task automatic send_beat(input logic [31:0] d, input bit last, input bit do_clr);
        int  waitc;
        bit  ok;
        waitc     = 0;
        drv_data  = d;
        drv_last  = last;
        drv_valid = 1'b1;
        clr       = do_clr;
        forever begin
            ok = cur_ready;   // value the next rising edge will sample
            @(negedge clk);
            if (ok) break;
            if (sel == 1) ready_low++;
            waitc++;
            if (waitc > 64) begin
                tests++; fails++;
                $display("FAIL accept_timeout: got no tready in 64 cycles expected accept");
                break;
            end
        end
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic send_frame(input int s, input int clr_at, input bit gaps);
        model_frame(s, clr_at);
        for (int k = 0; k < tx_q.size(); k++) begin
            if (gaps && ($urandom_range(0, 3) == 0))
                repeat ($urandom_range(1, 2)) @(negedge clk);
            send_beat(tx_q[k], k == tx_q.size() - 1, k == clr_at);
        end
    endtask

    task automatic make_frame(input int len);
        tx_q.delete();
        for (int k = 0; k < len; k++) tx_q.push_back(BASE + 32'(k));
    endtask

    task automatic make_random_frame();
        int kind;
        int len;
        kind = $urandom_range(0, 3);
        if (kind == 0)      len = $urandom_range(1, N - 1);
        else if (kind == 3) len = $urandom_range(N + 1, N + 8);
        else                len = N;
        make_frame(len);
        if ($urandom_range(0, 1) == 1) begin
            int p;
            p = $urandom_range(0, len - 1);
            tx_q[p] = tx_q[p] ^ (32'd1 << $urandom_range(0, 31));
        end
    endtask

    task automatic checkpoint(input int s, input string tag);
        int unsigned lim;
        repeat (3) @(negedge clk);
        check($sformatf("%s_frames_ok%0d", tag, s),  f_ok[s],  m_ok[s]);
        check($sformatf("%s_frames_bad%0d", tag, s), f_bad[s], m_bad[s]);
        check($sformatf("%s_beat_err%0d", tag, s),   b_err[s], m_berr[s]);
        check($sformatf("%s_sticky%0d", tag, s),     32'(stky[s]), 32'(m_sticky[s]));
        check($sformatf("%s_err_idx%0d", tag, s),    32'(cidx[s]), 32'(m_cidx[s]));
        check($sformatf("%s_err_data%0d", tag, s),   cdata[s], m_cdata[s]);
        check($sformatf("%s_pending%0d", tag, s),
              (s == 0) ? exp_q0.size() : exp_q1.size(), 0);
        if (s == 0) begin
            lim = SMALL_MX;
            check({tag, "_sat_ok"},   32'(s_ok),   (m_ok[0]   > lim) ? lim : m_ok[0]);
            check({tag, "_sat_bad"},  32'(s_bad),  (m_bad[0]  > lim) ? lim : m_bad[0]);
            check({tag, "_sat_berr"}, 32'(s_berr), (m_berr[0] > lim) ? lim : m_berr[0]);
        end
    endtask

    task automatic do_reset();
        aresetn   = 1'b0;
        clr       = 1'b0;
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        repeat (3) @(negedge clk);
        model_clr();
        exp_q0.delete();
        exp_q1.delete();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst_tready%0d", s), 32'((s == 0) ? if0.tready : if1.tready), 0);
            check($sformatf("rst_frames_ok%0d", s),  f_ok[s],  0);
            check($sformatf("rst_frames_bad%0d", s), f_bad[s], 0);
            check($sformatf("rst_beat_err%0d", s),   b_err[s], 0);
            check($sformatf("rst_sticky%0d", s),     32'(stky[s]), 0);
            check($sformatf("rst_err_idx%0d", s),    32'(cidx[s]), 0);
            check($sformatf("rst_err_data%0d", s),   cdata[s], 0);
            check($sformatf("rst_frame_done%0d", s), 32'(fdone[s]), 0);
            check($sformatf("rst_frame_ok%0d", s),   32'(fok[s]), 0);
        end
        aresetn = 1'b1;
        @(negedge clk);
        check("post_rst_tready0", 32'(if0.tready), 1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        sel       = 0;
        aresetn   = 1'b0;
        clr       = 1'b0;
        drv_data  = '0;
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        @(negedge clk);
        do_reset();

        // Single good frame
        make_frame(N);
        send_frame(0, -1, 0);
        checkpoint(0, "good");

        // Corrupted beat 5, then a second corrupted frame leaves capture alone
        make_frame(N);
        tx_q[5] = 32'hDEADBEEF;
        send_frame(0, -1, 0);
        checkpoint(0, "corrupt1");
        make_frame(N);
        tx_q[7] = 32'h12345678;
        send_frame(0, -1, 0);
        checkpoint(0, "corrupt2");

        // Idle clr, short frame then good frame
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clr();
        checkpoint(0, "clr_idle");
        make_frame(10);
        send_frame(0, -1, 0);
        make_frame(N);
        send_frame(0, -1, 0);
        checkpoint(0, "short");

        // Long frame (40 beats) then good frame
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clr();
        make_frame(40);
        send_frame(0, -1, 0);
        make_frame(N);
        send_frame(0, -1, 0);
        checkpoint(0, "long");

        // N_WORDS=1-style corner: single-beat frame is short here
        make_frame(1);
        send_frame(0, -1, 0);
        checkpoint(0, "one_beat");

        // Random frames with gaps; also drives the 3-bit counters into saturation
        for (int f = 0; f < 30; f++) begin
            make_random_frame();
            send_frame(0, -1, 1);
        end
        checkpoint(0, "rand0");

        // clr in the middle of a frame with mismatches before and after it
        make_frame(N);
        tx_q[3]  = 32'hBAD00003;
        tx_q[20] = 32'hCAFE0020;
        send_frame(0, 10, 0);
        checkpoint(0, "mid_clr");

        // Reset in the middle of a frame, then a good frame
        make_frame(N);
        for (int k = 0; k < 12; k++) send_beat(tx_q[k], 1'b0, 1'b0);
        do_reset();
        make_frame(N);
        send_frame(0, -1, 0);
        checkpoint(0, "mid_rst");

        // Throttled ready: 100 back-to-back good frames
        sel = 1;
        @(negedge clk);
        for (int f = 0; f < 100; f++) begin
            make_frame(N);
            send_frame(1, -1, 0);
        end
        checkpoint(1, "lfsr100");
        tests++;
        if (ready_low == 0) begin
            fails++;
            $display("FAIL tready_low_seen: got %0d low cycles expected >0", ready_low);
        end

        // Throttled ready with random faulty frames
        for (int f = 0; f < 15; f++) begin
            make_random_frame();
            send_frame(1, -1, 1);
        end
        checkpoint(1, "lfsr_rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
